add_4: RTL and testbench

4-bit ripple-carry adder with carry-in and carry-out, used as a leaf arithmetic cell in the datapath. The block has two result paths. The combinational path (`sum`, `cout`) settles within the same evaluation step as its inputs. The registered path (`sum_q`, `cout_q`, `ovf_q`) captures that result once per clock for pipelined consumers.

---
 rtl/add_4_pkg.sv | 7 +
 rtl/add_4_full_adder.sv | 17 +
 rtl/add_4.sv | 60 ++++++
 tb/tb_add_4.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/add_4_pkg.sv
// Shared constants for the add_4 datapath cell.
// Holds the fixed operand width used by the adder and its users.
package add_4_pkg;

    localparam int ADD4_W = 4;

endpackage

// File: rtl/add_4_full_adder.sv
// One-bit full adder, the leaf cell of the add_4 ripple chain.
// Ports: a, b, cin in; s sum bit, cout carry out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/add_4.sv
// 4-bit ripple-carry adder with combinational and registered results.
// Ports: clk, rst_n, a, b, cin in; sum, cout, sum_q, cout_q, ovf_q out.
module add_4
    import add_4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADD4_W-1:0] a,
    input  logic [ADD4_W-1:0] b,
    input  logic              cin,
    output logic [ADD4_W-1:0] sum,
    output logic              cout,
    output logic [ADD4_W-1:0] sum_q,
    output logic              cout_q,
    output logic              ovf_q
);

    logic [ADD4_W:0] c;
    logic            ovf;

    assign c[0] = cin;

    for (genvar i = 0; i < ADD4_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[ADD4_W];

    // Signed overflow: carry into the sign bit differs from carry out.
    assign ovf = c[ADD4_W-1] ^ c[ADD4_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

`ifndef SYNTHESIS
    // Inputs are stable at the clock edge, so the ripple chain has settled.
    always @(posedge clk) begin
        if (!$isunknown({a, b, cin})) begin
            a_sum : assert ({cout, sum} == 5'(a) + 5'(b) + 5'(cin));
            a_nox : assert (!$isunknown({sum, cout, ovf}));
        end
    end
`endif

endmodule

// File: tb/tb_add_4.sv
// Scoreboard bench for add_4: stimulus queues expectations,
// a monitor process pops and compares them against the DUT.
module tb_add_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic [3:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    add_4 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    typedef struct {
        bit       is_reg;
        string    name;
        bit [3:0] s;
        bit       c;
        bit       v;
    } exp_t;

    exp_t q[$];
    event chk;
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic drive(input logic [3:0] ia, input logic [3:0] ib,
                         input logic ic);
        a   = ia;
        b   = ib;
        cin = ic;
    endtask

    task automatic expect_comb(input string n, input bit [3:0] s,
                               input bit c);
        exp_t e;
        #1;
        e.is_reg = 1'b0;
        e.name   = n;
        e.s      = s;
        e.c      = c;
        e.v      = 1'b0;
        q.push_back(e);
        ->chk;
        #1;
    endtask

    task automatic expect_reg(input string n, input bit [3:0] s,
                              input bit c, input bit v);
        exp_t e;
        #1;
        e.is_reg = 1'b1;
        e.name   = n;
        e.s      = s;
        e.c      = c;
        e.v      = v;
        q.push_back(e);
        ->chk;
        #1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(chk);
            while (q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (e.is_reg) begin
                    if ({sum_q, cout_q, ovf_q} !== {e.s, e.c, e.v}) begin
                        bad++;
                        $display("FAIL %s: got sum_q=%0d cout_q=%0d ovf_q=%0d want %0d/%0d/%0d",
                                 e.name, sum_q, cout_q, ovf_q, e.s, e.c, e.v);
                    end
                end else begin
                    if ({sum, cout} !== {e.s, e.c}) begin
                        bad++;
                        $display("FAIL %s: got sum=%0d cout=%0d want %0d/%0d",
                                 e.name, sum, cout, e.s, e.c);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        clk   = 1'b0;
        rst_n = 1'b0;
        drive(4'd3, 4'd4, 1'b0);
        #1;

        // Reset state; combinational path live during reset.
        expect_reg("reset_regs", 4'd0, 1'b0, 1'b0);
        expect_comb("comb_in_reset", 4'd7, 1'b0);

        rst_n = 1'b1;

        // Exhaustive combinational sweep, no clock.
        for (int i = 0; i < 512; i++) begin
            drive(4'(i >> 5), 4'(i >> 1), i[0]);
            t = (i >> 5) + ((i >> 1) & 15) + (i & 1);
            expect_comb($sformatf("sweep_%0d", i), 4'(t & 15), t[4]);
        end

        // Corners
        drive(4'd15, 4'd15, 1'b1);
        expect_comb("c_15_15_1", 4'd15, 1'b1);
        drive(4'd0, 4'd0, 1'b0);
        expect_comb("c_0_0_0", 4'd0, 1'b0);
        drive(4'd15, 4'd0, 1'b1);
        expect_comb("c_15_0_1", 4'd0, 1'b1);
        drive(4'd8, 4'd8, 1'b0);
        expect_comb("c_8_8_0", 4'd0, 1'b1);

        // Overflow through the registered path
        drive(4'd7, 4'd1, 1'b0);
        tick();
        expect_reg("ovf_7_1", 4'd8, 1'b0, 1'b1);
        drive(4'd8, 4'd8, 1'b0);
        tick();
        expect_reg("ovf_8_8", 4'd0, 1'b1, 1'b1);
        drive(4'd3, 4'd4, 1'b0);
        tick();
        expect_reg("ovf_3_4", 4'd7, 1'b0, 1'b0);
        drive(4'd15, 4'd1, 1'b0);
        tick();
        expect_reg("ovf_15_1", 4'd0, 1'b1, 1'b0);

        // Latency and hold
        drive(4'd9, 4'd5, 1'b1);
        expect_reg("pre_load", 4'd0, 1'b1, 1'b0);
        tick();
        expect_reg("load_9_5_1", 4'd15, 1'b0, 1'b0);
        drive(4'd1, 4'd1, 1'b0);
        expect_reg("hold", 4'd15, 1'b0, 1'b0);
        expect_comb("hold_comb", 4'd2, 1'b0);

        // Asynchronous reset between edges
        rst_n = 1'b0;
        expect_reg("async_rst", 4'd0, 1'b0, 1'b0);
        expect_comb("rst_comb", 4'd2, 1'b0);
        drive(4'd6, 4'd9, 1'b1);
        expect_comb("rst_comb2", 4'd0, 1'b1);
        tick();
        expect_reg("edge_in_rst", 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_reg("released", 4'd0, 1'b0, 1'b0);
        tick();
        expect_reg("reload", 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 20 && q.size() != 0; i++) #1;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
